ap_mult_sched: RTL and testbench
================================

# ap_mult_sched

Round-robin scheduler that shares one approximate 12x12 signed multiplier among NREQ requesters. It contains the partial-product generator and the `ppcom` compression tree, wrapped as `ap_mult_core`, and puts an issue register and LAT-1 result stages around that core. It ends in a credit-protected response FIFO. It sits between requester ports (valid/ready) and a single shared response channel tagged with the requester id.

## Interface
- `NREQ`, default 4: number of requester ports, 2..8.
- `LAT`, default 2: cycles from an accepted request to its FIFO write, ≥1.
- `DEPTH`, default 4: response FIFO entries; also the credit pool size, ≥LAT.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  NREQ: request valid, one bit per requester.
- `req_ready`  out  NREQ: request accepted this cycle, one-hot or zero.
- `req_a`  in  NREQ*12: operand A; requester i uses bits [12i+:12]. Two's complement.
- `req_b`  in  NREQ*12: operand B, same packing as `req_a`.
- `rsp_valid`  out  1: response available at the FIFO head.
- `rsp_ready`  in  1: consumer takes the response.
- `rsp_id`  out  ID_W: requester index of the head response. ID_W = max(1, clog2(NREQ)).
- `rsp_data`  out  24: approximate product from `ap_mult_core`.
- `busy`  out  1: high while any request is in flight or the FIFO is non-empty.

## Operation
**Arbitration**
- `ptr` resets to 0.
- The grant goes to the lowest index ≥ `ptr` with `req_valid` set; if none, it wraps to the lowest index overall.
- The grant is taken only if `credits` > 0.
- `req_ready[g]` = grant valid && `credits` > 0. It is combinational from `req_valid` and registered state.
- On acceptance, `ptr` ← (g+1) mod NREQ. With no acceptance, `ptr` holds.

**Credits**
- `credits` resets to DEPTH.
- −1 on accept, +1 on pop (`rsp_valid && rsp_ready`). Both in the same cycle leaves it unchanged.
- It never underflows and never exceeds DEPTH. A violation is an assertion failure.

**Pipeline**
- On accept, the operands and the id are captured into the stage-0 register with its valid bit.
- `ap_mult_core` is combinational and evaluates on stage 0.
- Its product and the id then pass through LAT-1 further registers. With LAT=1 the product is written straight from stage 0.
- The last stage's valid bit writes the FIFO.
- The pipeline never stalls. The credit rule guarantees FIFO space for every in-flight operation.

**FIFO**
- Show-ahead, DEPTH entries, {id, data}.
- Read and write in the same cycle are both allowed, including when full (credits prevent overflow) and when empty (write-through is not required).

**Ordering**
- Responses leave in acceptance order.
- A requester may have up to DEPTH outstanding requests.

**Reset mid-operation**
- All in-flight operations and FIFO contents are discarded.
- `credits` returns to DEPTH and `ptr` to 0.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0. `req_ready` follows `req_valid` combinationally (credits = DEPTH after reset).
- Accept at edge k → FIFO write at edge k+LAT → `rsp_valid` is high during the cycle after edge k+LAT, provided the FIFO was empty.
- Sustained throughput is one operation per cycle while the consumer holds `rsp_ready` high.
- With `rsp_ready` low, at most DEPTH acceptances occur, then all `req_ready` stay 0.
- A pop at edge j frees a credit; the next acceptance can occur in the cycle after edge j.
- `busy` is registered. It is 1 from the edge after the first accept until the edge after the last pop with nothing in flight.

## Structure
- Package `ap_mult_pkg` holds:
  - `AW`=12 and `PW`=24.
  - the `ID_W` function.
  - the FIFO entry struct `rsp_t` {id, data}.
- Sub-module `ap_mult_core`: Baugh-Wooley partial-product generation into 144 bits, then a `ppcom` instance. It is purely combinational.
- The FIFO is inline: DEPTH-entry array with wrapping read/write pointers and an occupancy count.

## Test plan
All expected data comes from a standalone `ap_mult_core` golden model. NREQ=4, LAT=2, DEPTH=4.
- Single request: requester 2 sends A=0x005, B=0x003 at edge 0 → `req_ready`=0b0100; `rsp_valid` is high during the cycle after edge 2 with `rsp_id`=2 and `rsp_data` equal to the model result.
- All four requesters held valid, `rsp_ready`=1 → grants 0,1,2,3,0,… one per cycle; `rsp_id` comes back in the same order; back-to-back `rsp_valid` with no gaps.
- `rsp_ready`=0 with requester 1 held valid → exactly 4 acceptances, then `req_ready`=0. Raising `rsp_ready` for one cycle → one pop and, in the next cycle, exactly one more acceptance.
- Simultaneous accept and pop with credits=1 → credits stays 1 and the FIFO count is unchanged. Boundaries: A=0x800, B=0x800 and A=0x7FF, B=0x801 match the model.
- `rst_n` pulsed low with 3 operations in flight → no `rsp_valid` afterward; after reset `busy`=0, credits=4, and the first grant goes to requester 0.
- Random 10k-cycle traffic with random `rsp_ready` → scoreboard: per-requester in-order data matches the model, no loss or duplication, and the credit assertion never fires.

Source files
------------

// File: rtl/ap_mult_pkg.sv
// Shared widths, response entry type and id-width helper for the
// approximate-multiplier scheduler.
package ap_mult_pkg;

  localparam int AW       = 12;
  localparam int PW       = 24;
  localparam int APX_COLS = 4;
  localparam int MAX_ID_W = 3;

  function automatic int id_w(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  // The id field is sized for the largest legal NREQ; narrower configs use its low bits.
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [PW-1:0]       data;
  } rsp_t;

endpackage

// File: rtl/ap_mult_sched_if.sv
// Requester and response channel bundle between the requesters/consumer
// and the shared multiplier scheduler.
interface ap_mult_sched_if import ap_mult_pkg::*; #(
  parameter int NREQ = 4
) ();

  localparam int ID_W = id_w(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*AW-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [PW-1:0]      rsp_data;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/ap_mult_sched_core.sv
// Approximate signed 12x12 multiplier: Baugh-Wooley partial products feeding
// a compression stage that drops the lowest APX_COLS product columns.
module ppcom import ap_mult_pkg::*; (
  input  logic [AW*AW-1:0] pp_i,
  output logic [PW-1:0]    sum_o
);

  // Seeded with the Baugh-Wooley correction ones at columns AW and PW-1.
  always_comb begin
    sum_o = (PW'(1) << AW) | (PW'(1) << (PW - 1));
    for (int r = 0; r < AW; r++) begin
      for (int c = 0; c < AW; c++) begin
        if (r + c >= APX_COLS) begin
          sum_o = sum_o + (PW'(pp_i[r*AW + c]) << (r + c));
        end
      end
    end
  end

endmodule

module ap_mult_core import ap_mult_pkg::*; (
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] b_i,
  output logic [PW-1:0] p_o
);

  logic [AW*AW-1:0] pp;

  // Terms pairing exactly one sign bit with a magnitude bit are inverted.
  always_comb begin
    pp = '0;
    for (int r = 0; r < AW; r++) begin
      for (int c = 0; c < AW; c++) begin
        if ((r == AW - 1) != (c == AW - 1)) begin
          pp[r*AW + c] = ~(a_i[c] & b_i[r]);
        end else begin
          pp[r*AW + c] = a_i[c] & b_i[r];
        end
      end
    end
  end

  ppcom uPpcom (
    .pp_i  (pp),
    .sum_o (p_o)
  );

endmodule

// File: rtl/ap_mult_sched.sv
// Round-robin scheduler sharing one approximate multiplier among NREQ
// requesters, with credit-protected in-order response FIFO.
module ap_mult_sched import ap_mult_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  ap_mult_sched_if.slave bus
);

  localparam int ID_W = id_w(NREQ);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0] ptr_q, ptr_d, grantIdx;
  logic            grantVld, accept, pop, headVld, busy_d, busy_q;
  logic [CW-1:0]   credits_q, credits_d;
  logic            s0Vld_q;
  logic [AW-1:0]   s0A_q, s0B_q;
  logic [ID_W-1:0] s0Id_q;
  logic [PW-1:0]   product;
  rsp_t            s0Ent, wrEnt, head;
  logic            wrVld;
  rsp_t            mem_q [DEPTH];
  logic [PTRW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0]   count_q;

  // First pass finds the lowest requester overall; the second overrides it with the lowest at or above ptr.
  always_comb begin
    grantVld = 1'b0;
    grantIdx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        grantVld = 1'b1;
        grantIdx = ID_W'(k);
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k] && k >= int'(ptr_q)) begin
        grantIdx = ID_W'(k);
      end
    end
  end

  assign accept        = grantVld && (credits_q != '0);
  assign headVld       = (count_q != '0);
  assign pop           = headVld && bus.rsp_ready;
  assign bus.req_ready = accept ? (NREQ'(1) << grantIdx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (int'(grantIdx) == NREQ - 1) ? '0 : grantIdx + ID_W'(1);
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) begin
      credits_d = credits_q - CW'(1);
    end else if (!accept && pop) begin
      credits_d = credits_q + CW'(1);
    end
  end

  // A credit is held from acceptance until the matching response is popped, so any non-full pool means work is pending.
  assign busy_d = (credits_d != CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      credits_q <= CW'(DEPTH);
      busy_q    <= 1'b0;
      s0Vld_q   <= 1'b0;
      s0A_q     <= '0;
      s0B_q     <= '0;
      s0Id_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      busy_q    <= busy_d;
      s0Vld_q   <= accept;
      if (accept) begin
        s0A_q  <= bus.req_a[grantIdx*AW +: AW];
        s0B_q  <= bus.req_b[grantIdx*AW +: AW];
        s0Id_q <= grantIdx;
      end
    end
  end

  ap_mult_core uCore (
    .a_i (s0A_q),
    .b_i (s0B_q),
    .p_o (product)
  );

  assign s0Ent = {MAX_ID_W'(s0Id_q), product};

  if (LAT == 1) begin : gDirect
    assign wrVld = s0Vld_q;
    assign wrEnt = s0Ent;
  end else begin : gPipe
    logic [LAT-2:0] pVld_q;
    rsp_t           pEnt_q [LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pVld_q <= '0;
      end else begin
        pVld_q[0] <= s0Vld_q;
        for (int k = 1; k < LAT - 1; k++) begin
          pVld_q[k] <= pVld_q[k-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      pEnt_q[0] <= s0Ent;
      for (int k = 1; k < LAT - 1; k++) begin
        pEnt_q[k] <= pEnt_q[k-1];
      end
    end

    assign wrVld = pVld_q[LAT-2];
    assign wrEnt = pEnt_q[LAT-2];
  end

  always_ff @(posedge clk) begin
    if (wrVld) begin
      mem_q[wrPtr_q] <= wrEnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrVld) begin
        wrPtr_q <= (int'(wrPtr_q) == DEPTH - 1) ? '0 : wrPtr_q + PTRW'(1);
      end
      if (pop) begin
        rdPtr_q <= (int'(rdPtr_q) == DEPTH - 1) ? '0 : rdPtr_q + PTRW'(1);
      end
      if (wrVld && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!wrVld && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Head is forced to zero when empty so stale storage never shows on the response channel.
  assign head          = mem_q[rdPtr_q];
  assign bus.rsp_valid = headVld;
  assign bus.rsp_id    = headVld ? head.id[ID_W-1:0] : '0;
  assign bus.rsp_data  = headVld ? head.data : '0;
  assign bus.busy      = busy_q;

  aCreditMax: assert property (@(posedge clk) disable iff (!rst_n)
    credits_q <= CW'(DEPTH));
  aCreditOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !accept && credits_q == CW'(DEPTH)));
  aFifoOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wrVld && !pop && count_q == CW'(DEPTH)));
  aIdRange: assert property (@(posedge clk) disable iff (!rst_n)
    !headVld || (32'(head.id) < NREQ));

endmodule

// File: tb/tb_ap_mult_sched.sv
// Bench for ap_mult_sched: directed scenarios plus random traffic, checked
// against a queue model of acceptance order and an arithmetic product model.
module tb_ap_mult_sched;
  import ap_mult_pkg::*;

  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef struct {
    int            id;
    logic [PW-1:0] data;
    int            vis;
  } expT;

  logic            clk = 1'b0;
  logic            rst_n;
  int              assertCount = 0;
  int              failCount = 0;
  int              cyc = 0;
  expT             expQ[$];
  int              modelPtr = 0;
  int              acceptCount = 0;
  int              popCount = 0;
  logic [NREQ-1:0] drvValid = '0;
  logic [AW-1:0]   drvA [NREQ];
  logic [AW-1:0]   drvB [NREQ];
  logic            drvRspReady = 1'b0;
  int              lastGrant;
  logic [NREQ-1:0] lastReady;
  logic            lastRspValid, lastBusy;
  logic [31:0]     lastId;
  logic [PW-1:0]   lastData;

  ap_mult_sched_if #(.NREQ(NREQ)) bus ();

  ap_mult_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact signed product minus every a_i*b_j term whose weight falls below 2^APX_COLS.
  function automatic logic [PW-1:0] modelMult(input logic [AW-1:0] a, input logic [AW-1:0] b);
    int exact, dropped;
    exact   = int'($signed(a)) * int'($signed(b));
    dropped = 0;
    for (int i = 0; i < AW; i++)
      for (int j = 0; j < AW; j++)
        if (i + j < APX_COLS && a[i] && b[j]) dropped += 1 << (i + j);
    return PW'(exact - dropped);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive, check against the model, update the model, advance to the next negedge.
  task automatic applyStimulus();
    int              g;
    logic            expVisible;
    logic [NREQ-1:0] expReady;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*AW +: AW] = drvA[i];
      bus.req_b[i*AW +: AW] = drvB[i];
    end
    bus.req_valid = drvValid;
    bus.rsp_ready = drvRspReady;
    #1;
    checkOutput("busy", 32'(bus.busy), 32'(expQ.size() != 0));
    expVisible = (expQ.size() != 0) && (expQ[0].vis <= cyc);
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(expVisible));
    g = -1;
    if (expQ.size() < DEPTH)
      for (int off = 0; off < NREQ; off++)
        if (g < 0 && drvValid[(modelPtr + off) % NREQ]) g = (modelPtr + off) % NREQ;
    expReady = (g >= 0) ? (NREQ'(1) << g) : '0;
    checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
    lastReady    = bus.req_ready;
    lastRspValid = bus.rsp_valid;
    lastBusy     = bus.busy;
    lastId       = 32'(bus.rsp_id);
    lastData     = bus.rsp_data;
    if (bus.rsp_valid && drvRspReady) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        checkOutput("rsp_id", 32'(bus.rsp_id), 32'(expQ[0].id));
        checkOutput("rsp_data", 32'(bus.rsp_data), 32'(expQ[0].data));
        void'(expQ.pop_front());
        popCount++;
      end
    end
    if (g >= 0) begin
      expQ.push_back('{id: g, data: modelMult(drvA[g], drvB[g]), vis: cyc + 1 + LAT});
      modelPtr = (g + 1) % NREQ;
      acceptCount++;
    end
    lastGrant = g;
    @(negedge clk);
  endtask

  task automatic applyReset();
    drvValid      = '0;
    drvRspReady   = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    modelPtr    = 0;
    acceptCount = 0;
    popCount    = 0;
  endtask

  function automatic int onehotIdx(input logic [NREQ-1:0] v);
    int idx = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  initial begin
    int accepts;
    for (int i = 0; i < NREQ; i++) begin
      drvA[i] = '0;
      drvB[i] = '0;
    end
    applyReset();

    // Single request from requester 2.
    drvValid = 4'b0100; drvA[2] = 12'h005; drvB[2] = 12'h003;
    applyStimulus();
    checkOutput("single_ready", 32'(lastReady), 32'b0100);
    drvValid = '0; drvRspReady = 1'b1;
    for (int n = 0; n < 3; n++) begin
      applyStimulus();
      checkOutput($sformatf("single_valid_%0d", n), 32'(lastRspValid), 32'(n == 2));
    end
    checkOutput("single_id", lastId, 32'd2);
    checkOutput("single_data", 32'(lastData), 32'(modelMult(12'h005, 12'h003)));

    // All requesters valid, consumer always ready.
    applyReset();
    drvValid = '1; drvRspReady = 1'b1;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        drvA[i] = AW'($urandom);
        drvB[i] = AW'($urandom);
      end
      applyStimulus();
      checkOutput($sformatf("rr_grant_%0d", n), 32'(onehotIdx(lastReady)), 32'(n % NREQ));
      if (n >= LAT + 1) begin
        checkOutput($sformatf("b2b_valid_%0d", n), 32'(lastRspValid), 32'd1);
        checkOutput($sformatf("b2b_id_%0d", n), lastId, 32'((n - LAT - 1) % NREQ));
      end
    end

    // Consumer stalled: credits cap acceptances at DEPTH.
    applyReset();
    drvValid = 4'b0010; drvRspReady = 1'b0;
    accepts = 0;
    for (int n = 0; n < 8; n++) begin
      applyStimulus();
      if (lastReady != '0) accepts++;
    end
    checkOutput("stall_accepts", 32'(accepts), 32'(DEPTH));
    checkOutput("stall_ready_low", 32'(lastReady), 32'd0);
    drvRspReady = 1'b1;
    applyStimulus();
    checkOutput("stall_pop_ready", 32'(lastReady), 32'd0);
    drvRspReady = 1'b0;
    applyStimulus();
    checkOutput("credit_return_ready", 32'(lastReady), 32'b0010);
    applyStimulus();
    checkOutput("credit_spent_ready", 32'(lastReady), 32'd0);

    // Accept and pop together with one credit left, boundary operands.
    applyReset();
    drvValid = 4'b0001; drvA[0] = 12'h800; drvB[0] = 12'h800;
    applyStimulus();
    drvA[0] = 12'h7FF; drvB[0] = 12'h801;
    applyStimulus();
    drvA[0] = AW'($urandom); drvB[0] = AW'($urandom);
    applyStimulus();
    drvValid = '0;
    applyStimulus();
    applyStimulus();
    drvValid = 4'b1000; drvA[3] = 12'h801; drvB[3] = 12'h7FF; drvRspReady = 1'b1;
    applyStimulus();
    checkOutput("acc_pop_ready", 32'(lastReady), 32'b1000);
    drvRspReady = 1'b0;
    applyStimulus();
    checkOutput("acc_pop_credit_kept", 32'(lastReady), 32'b1000);
    applyStimulus();
    checkOutput("acc_pop_credit_gone", 32'(lastReady), 32'd0);
    drvValid = '0; drvRspReady = 1'b1;
    for (int n = 0; n < 8; n++) applyStimulus();
    checkOutput("boundary_drained", 32'(expQ.size()), 32'd0);

    // Reset with three operations in flight.
    applyReset();
    drvValid = 4'b0111; drvRspReady = 1'b0;
    for (int n = 0; n < 3; n++) applyStimulus();
    applyReset();
    for (int n = 0; n < 4; n++) begin
      applyStimulus();
      checkOutput($sformatf("stale_rsp_%0d", n), 32'(lastRspValid), 32'd0);
      checkOutput($sformatf("post_reset_busy_%0d", n), 32'(lastBusy), 32'd0);
    end
    drvValid = '1;
    accepts = 0;
    for (int n = 0; n < 6; n++) begin
      applyStimulus();
      if (n == 0) checkOutput("post_reset_grant", 32'(lastReady), 32'b0001);
      if (lastReady != '0) accepts++;
    end
    checkOutput("post_reset_credits", 32'(accepts), 32'(DEPTH));

    // Random traffic; a pending request stays valid until accepted.
    applyReset();
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!drvValid[i] && $urandom_range(0, 3) == 0) begin
          drvValid[i] = 1'b1;
          drvA[i] = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 12'h800 : 12'h7FF) : AW'($urandom);
          drvB[i] = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 12'h801 : 12'h800) : AW'($urandom);
        end
      end
      drvRspReady = ($urandom_range(0, 9) < 6);
      applyStimulus();
      if (lastGrant >= 0) drvValid[lastGrant] = 1'b0;
    end
    drvValid = '0; drvRspReady = 1'b1;
    for (int n = 0; n < 40 && expQ.size() != 0; n++) applyStimulus();
    checkOutput("random_drained", 32'(expQ.size()), 32'd0);
    checkOutput("random_no_loss", 32'(popCount), 32'(acceptCount));
    applyStimulus();
    checkOutput("random_final_busy", 32'(lastBusy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
